tlul_dw64_downsizer: RTL

//  TL-UL width adapter between a 64-bit host port (TL_DW64, TL_SZW64) and a 32-bit device port (TL_DW, TL_SZW).

---
 rtl/tlul_dw64_downsizer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tlul_dw64_downsizer.sv
// rtl/tlul_dw64_downsizer.sv - TL-UL 64-bit host to 32-bit device width adapter
module tlul_dw64_downsizer #(
    parameter int AW  = 32,
    parameter int AIW = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           h_a_valid_i,
    output logic           h_a_ready_o,
    input  logic [2:0]     h_a_opcode_i,
    input  logic [1:0]     h_a_size_i,
    input  logic [AIW-1:0] h_a_source_i,
    input  logic [AW-1:0]  h_a_addr_i,
    input  logic [7:0]     h_a_mask_i,
    input  logic [63:0]    h_a_data_i,
    output logic           h_d_valid_o,
    input  logic           h_d_ready_i,
    output logic [2:0]     h_d_opcode_o,
    output logic [1:0]     h_d_size_o,
    output logic [AIW-1:0] h_d_source_o,
    output logic [63:0]    h_d_data_o,
    output logic           h_d_error_o,
    output logic           d_a_valid_o,
    input  logic           d_a_ready_i,
    output logic [2:0]     d_a_opcode_o,
    output logic [1:0]     d_a_size_o,
    output logic [AIW-1:0] d_a_source_o,
    output logic [AW-1:0]  d_a_addr_o,
    output logic [3:0]     d_a_mask_o,
    output logic [31:0]    d_a_data_o,
    input  logic           d_d_valid_i,
    output logic           d_d_ready_o,
    input  logic [31:0]    d_d_data_i,
    input  logic           d_d_error_i
);

    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, RESP} state_e;

    localparam logic [2:0] OP_GET = 3'd4;

    state_e         state_q, state_d;
    logic [2:0]     opcode_q, opcode_d;
    logic [1:0]     size_q, size_d;
    logic [AIW-1:0] source_q, source_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [3:0]     mask_hi_q, mask_hi_d;
    logic [31:0]    wdata_hi_q, wdata_hi_d;
    logic           two_beat_q, two_beat_d;
    logic           lane_q, lane_d;
    logic           err_q, err_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           h_a_ready_q, h_a_ready_d;
    logic           d_a_valid_q, d_a_valid_d;
    logic           d_d_ready_q, d_d_ready_d;
    logic           h_d_valid_q, h_d_valid_d;
    logic [AW-1:0]  da_addr_q, da_addr_d;
    logic [3:0]     da_mask_q, da_mask_d;
    logic [31:0]    da_data_q, da_data_d;
    logic [1:0]     da_size_q, da_size_d;

    logic misaligned;
    logic first_lane;

    assign misaligned = ((h_a_size_i == 2'd3) && (h_a_addr_i[2:0] != 3'd0)) ||
                        ((h_a_size_i == 2'd2) && (h_a_addr_i[1:0] != 2'd0));
    // An 8-byte access always starts on the low lane; narrower ones use the addressed lane.
    assign first_lane = (h_a_size_i == 2'd3) ? 1'b0 : h_a_addr_i[2];

    // Next-state and next-output computation for the split/merge sequencer.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        size_d      = size_q;
        source_d    = source_q;
        addr_d      = addr_q;
        mask_hi_d   = mask_hi_q;
        wdata_hi_d  = wdata_hi_q;
        two_beat_d  = two_beat_q;
        lane_d      = lane_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        h_a_ready_d = h_a_ready_q;
        d_a_valid_d = d_a_valid_q;
        d_d_ready_d = d_d_ready_q;
        h_d_valid_d = h_d_valid_q;
        da_addr_d   = da_addr_q;
        da_mask_d   = da_mask_q;
        da_data_d   = da_data_q;
        da_size_d   = da_size_q;
        case (state_q)
            IDLE: begin
                if (h_a_valid_i && h_a_ready_q) begin
                    opcode_d    = h_a_opcode_i;
                    size_d      = h_a_size_i;
                    source_d    = h_a_source_i;
                    addr_d      = h_a_addr_i;
                    mask_hi_d   = h_a_mask_i[7:4];
                    wdata_hi_d  = h_a_data_i[63:32];
                    two_beat_d  = (h_a_size_i == 2'd3);
                    lane_d      = first_lane;
                    err_d       = misaligned;
                    rdata_d     = '0;
                    h_a_ready_d = 1'b0;
                    da_addr_d   = h_a_addr_i;
                    da_mask_d   = first_lane ? h_a_mask_i[7:4] : h_a_mask_i[3:0];
                    da_data_d   = first_lane ? h_a_data_i[63:32] : h_a_data_i[31:0];
                    da_size_d   = (h_a_size_i == 2'd3) ? 2'd2 : h_a_size_i;
                    if (misaligned) begin
                        state_d     = RESP;
                        h_d_valid_d = 1'b1;
                    end else begin
                        state_d     = REQ0;
                        d_a_valid_d = 1'b1;
                    end
                end
            end
            REQ0, REQ1: begin
                if (d_a_ready_i) begin
                    d_a_valid_d = 1'b0;
                    d_d_ready_d = 1'b1;
                    state_d     = (state_q == REQ0) ? RSP0 : RSP1;
                end
            end
            RSP0, RSP1: begin
                if (d_d_valid_i && d_d_ready_q) begin
                    if (lane_q) begin
                        rdata_d[63:32] = d_d_data_i;
                    end else begin
                        rdata_d[31:0] = d_d_data_i;
                    end
                    err_d       = err_q | d_d_error_i;
                    d_d_ready_d = 1'b0;
                    if ((state_q == RSP0) && two_beat_q) begin
                        state_d     = REQ1;
                        d_a_valid_d = 1'b1;
                        lane_d      = 1'b1;
                        da_addr_d   = addr_q + AW'(4);
                        da_mask_d   = mask_hi_q;
                        da_data_d   = wdata_hi_q;
                    end else begin
                        state_d     = RESP;
                        h_d_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (h_d_ready_i) begin
                    state_d     = IDLE;
                    h_d_valid_d = 1'b0;
                    h_a_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                h_a_ready_d = 1'b1;
                d_a_valid_d = 1'b0;
                d_d_ready_d = 1'b0;
                h_d_valid_d = 1'b0;
            end
        endcase
    end

    // State, latched request/response context and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            size_q      <= '0;
            source_q    <= '0;
            addr_q      <= '0;
            mask_hi_q   <= '0;
            wdata_hi_q  <= '0;
            two_beat_q  <= 1'b0;
            lane_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            h_a_ready_q <= 1'b1;
            d_a_valid_q <= 1'b0;
            d_d_ready_q <= 1'b0;
            h_d_valid_q <= 1'b0;
            da_addr_q   <= '0;
            da_mask_q   <= '0;
            da_data_q   <= '0;
            da_size_q   <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            size_q      <= size_d;
            source_q    <= source_d;
            addr_q      <= addr_d;
            mask_hi_q   <= mask_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            two_beat_q  <= two_beat_d;
            lane_q      <= lane_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            h_a_ready_q <= h_a_ready_d;
            d_a_valid_q <= d_a_valid_d;
            d_d_ready_q <= d_d_ready_d;
            h_d_valid_q <= h_d_valid_d;
            da_addr_q   <= da_addr_d;
            da_mask_q   <= da_mask_d;
            da_data_q   <= da_data_d;
            da_size_q   <= da_size_d;
        end
    end

    assign h_a_ready_o  = h_a_ready_q;
    assign d_a_valid_o  = d_a_valid_q;
    assign d_a_opcode_o = opcode_q;
    assign d_a_size_o   = da_size_q;
    assign d_a_source_o = source_q;
    assign d_a_addr_o   = da_addr_q;
    assign d_a_mask_o   = da_mask_q;
    assign d_a_data_o   = da_data_q;
    assign d_d_ready_o  = d_d_ready_q;
    assign h_d_valid_o  = h_d_valid_q;
    assign h_d_opcode_o = (opcode_q == OP_GET) ? 3'd1 : 3'd0;
    assign h_d_size_o   = size_q;
    assign h_d_source_o = source_q;
    // Writes return zero data regardless of what the device drove back.
    assign h_d_data_o   = (opcode_q == OP_GET) ? rdata_q : 64'd0;
    assign h_d_error_o  = err_q;

endmodule
